// File: rtl/adc_capture_pkg.sv
// Shared definitions for the ADC capture sequencer: FSM state encoding,
// default minimum clear-hold length and the trigger-level disarm value.
package adc_capture_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_ARMED   = 3'd3,
    ST_CAPTURE = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  // Cycles the datapath needs to flush its 3-stage pipeline, plus margin
  localparam int MIN_SETTLE_DEFAULT = 4;

  // Threshold no 16-bit sum can exceed, used as the reset trigger level
  localparam logic [15:0] TRIG_LEVEL_DISARM = 16'hFFFF;

endpackage

// File: rtl/adc_capture_outreg.sv
// Single-entry AXI-Stream output register. Accepts a sample when empty or
// draining in the same cycle; otherwise the sample is dropped and 'drop'
// pulses. 'flush' empties the register without emitting its contents.
module adc_capture_outreg (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        flush,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  input  logic        in_last,
  output logic        m_axis_tvalid,
  output logic [15:0] m_axis_tdata,
  output logic        m_axis_tlast,
  input  logic        m_axis_tready,
  output logic        drop
);

  logic        valid_reg;
  logic [15:0] data_reg;
  logic        last_reg;
  logic        drain;
  logic        load;

  assign drain = valid_reg && m_axis_tready;
  assign load  = in_valid && (!valid_reg || drain);
  assign drop  = in_valid && valid_reg && !m_axis_tready;

  assign m_axis_tvalid = valid_reg;
  assign m_axis_tdata  = data_reg;
  assign m_axis_tlast  = last_reg;

  // Holding register: load, drain or flush
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
      last_reg  <= 1'b0;
    end else if (flush) begin
      valid_reg <= 1'b0;
      last_reg  <= 1'b0;
    end else if (load) begin
      valid_reg <= 1'b1;
      data_reg  <= in_data;
      last_reg  <= in_last;
    end else if (drain) begin
      valid_reg <= 1'b0;
      last_reg  <= 1'b0;
    end
  end

endmodule

// File: rtl/adc_capture_ctrl.sv
// ADC capture sequencer: arms the trigger datapath, holds it in reset while
// its pipeline flushes, then forwards a fixed number of post-trigger samples
// to the DMA stream. Optional macro ADC_CAPTURE_PEAK_EN adds sts_peak, the
// largest sample seen during the capture.
module adc_capture_ctrl
  import adc_capture_pkg::*;
#(
  parameter int CNT_W      = 32,
  parameter int TS_W       = 64,
  parameter int MIN_SETTLE = MIN_SETTLE_DEFAULT
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             cfg_arm,
  input  logic             cfg_abort,
  input  logic [15:0]      cfg_trig_level,
  input  logic [CNT_W-1:0] cfg_post_len,
  input  logic [7:0]       cfg_settle,
  output logic [15:0]      adc_trigger_level,
  output logic             adc_reset_trigger,
  output logic             adc_reset_max_sum,
  input  logic             s_axis_tvalid,
  input  logic [15:0]      s_axis_tdata,
  output logic             m_axis_tvalid,
  output logic [15:0]      m_axis_tdata,
  output logic             m_axis_tlast,
  input  logic             m_axis_tready,
  output logic [2:0]       sts_state,
  output logic             sts_done,
  output logic             sts_overflow,
  output logic [CNT_W-1:0] sts_count,
`ifdef ADC_CAPTURE_PEAK_EN
  output logic [15:0]      sts_peak,
`endif
  output logic [TS_W-1:0]  sts_trig_time
);

  localparam logic [7:0] MIN_SETTLE_B = 8'(MIN_SETTLE);

  state_t           state_reg, state_next;
  logic [TS_W-1:0]  ts_reg;
  logic [15:0]      trig_level_reg;
  logic [CNT_W-1:0] post_len_reg;
  logic [7:0]       settle_reg;
  logic [7:0]       settle_cnt_reg;
  logic [CNT_W-1:0] count_reg;
  logic [TS_W-1:0]  trig_time_reg;
  logic             done_reg;
  logic             overflow_reg;
  logic [7:0]       settle_len;
  logic             arm_ok;
  logic             sample;
  logic             last_sample;
  logic             drop;

  // Arm is only honoured when idle or finished; abort always takes priority
  assign arm_ok      = cfg_arm && !cfg_abort && (state_reg == ST_IDLE || state_reg == ST_DONE);
  assign sample      = s_axis_tvalid && !cfg_abort && (state_reg == ST_ARMED || state_reg == ST_CAPTURE);
  assign last_sample = sample && (count_reg == post_len_reg - 1'b1);
  assign settle_len  = (settle_reg > MIN_SETTLE_B) ? settle_reg : MIN_SETTLE_B;

  assign adc_trigger_level = trig_level_reg;
  assign sts_state         = state_reg;
  assign sts_done          = done_reg;
  assign sts_overflow      = overflow_reg;
  assign sts_count         = count_reg;
  assign sts_trig_time     = trig_time_reg;

  // FSM state register
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state_reg <= ST_IDLE;
    else          state_reg <= state_next;
  end

  // Next state and datapath reset controls
  always_comb begin
    state_next        = state_reg;
    adc_reset_trigger = 1'b1;
    adc_reset_max_sum = 1'b0;
    case (state_reg)
      ST_IDLE, ST_DONE: if (arm_ok) state_next = ST_CLEAR;
      ST_CLEAR: begin
        adc_reset_max_sum = 1'b1;
        state_next        = ST_SETTLE;
      end
      ST_SETTLE: if (settle_cnt_reg == 8'd0) state_next = ST_ARMED;
      ST_ARMED: begin
        adc_reset_trigger = 1'b0;
        if (sample) state_next = last_sample ? ST_DONE : ST_CAPTURE;
      end
      ST_CAPTURE: begin
        adc_reset_trigger = 1'b0;
        if (last_sample) state_next = ST_DONE;
      end
      default: state_next = ST_IDLE;
    endcase
    if (cfg_abort) state_next = ST_IDLE;
  end

  // Timestamp, latched configuration, settle timer and capture status
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ts_reg         <= '0;
      trig_level_reg <= TRIG_LEVEL_DISARM;
      post_len_reg   <= CNT_W'(1);
      settle_reg     <= '0;
      settle_cnt_reg <= '0;
      count_reg      <= '0;
      trig_time_reg  <= '0;
      done_reg       <= 1'b0;
      overflow_reg   <= 1'b0;
    end else begin
      ts_reg <= ts_reg + 1'b1;
      if (arm_ok) begin
        trig_level_reg <= cfg_trig_level;
        // A zero length would never terminate; capture a single sample instead
        post_len_reg   <= (cfg_post_len == '0) ? CNT_W'(1) : cfg_post_len;
        settle_reg     <= cfg_settle;
        count_reg      <= '0;
        done_reg       <= 1'b0;
        overflow_reg   <= 1'b0;
      end
      // Loaded in CLEAR so SETTLE lasts exactly settle_len cycles
      if (state_reg == ST_CLEAR)
        settle_cnt_reg <= settle_len - 8'd1;
      else if (state_reg == ST_SETTLE && settle_cnt_reg != 8'd0)
        settle_cnt_reg <= settle_cnt_reg - 8'd1;
      if (sample) begin
        count_reg <= count_reg + 1'b1;
        if (state_reg == ST_ARMED) trig_time_reg <= ts_reg;
      end
      if (drop) overflow_reg <= 1'b1;
      if (cfg_abort)        done_reg <= 1'b0;
      else if (last_sample) done_reg <= 1'b1;
    end
  end

`ifdef ADC_CAPTURE_PEAK_EN
  logic [15:0] peak_reg;
  assign sts_peak = peak_reg;

  // Running maximum of the samples taken in the current capture
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)                              peak_reg <= '0;
    else if (arm_ok)                           peak_reg <= '0;
    else if (sample && s_axis_tdata > peak_reg) peak_reg <= s_axis_tdata;
  end
`endif

  adc_capture_outreg u_outreg (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .flush         (cfg_abort),
    .in_valid      (sample),
    .in_data       (s_axis_tdata),
    .in_last       (last_sample),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .drop          (drop)
  );

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Directed testbench for adc_capture_ctrl. Build with ADC_CAPTURE_PEAK_EN
// defined to include the peak-hold checks.
module tb_adc_capture_ctrl;

  logic        aclk;
  logic        aresetn;
  logic        cfg_arm;
  logic        cfg_abort;
  logic [15:0] cfg_trig_level;
  logic [31:0] cfg_post_len;
  logic [7:0]  cfg_settle;
  logic [15:0] adc_trigger_level;
  logic        adc_reset_trigger;
  logic        adc_reset_max_sum;
  logic        s_axis_tvalid;
  logic [15:0] s_axis_tdata;
  logic        m_axis_tvalid;
  logic [15:0] m_axis_tdata;
  logic        m_axis_tlast;
  logic        m_axis_tready;
  logic [2:0]  sts_state;
  logic        sts_done;
  logic        sts_overflow;
  logic [31:0] sts_count;
`ifdef ADC_CAPTURE_PEAK_EN
  logic [15:0] sts_peak;
`endif
  logic [63:0] sts_trig_time;

  adc_capture_ctrl dut (
    .aclk              (aclk),
    .aresetn           (aresetn),
    .cfg_arm           (cfg_arm),
    .cfg_abort         (cfg_abort),
    .cfg_trig_level    (cfg_trig_level),
    .cfg_post_len      (cfg_post_len),
    .cfg_settle        (cfg_settle),
    .adc_trigger_level (adc_trigger_level),
    .adc_reset_trigger (adc_reset_trigger),
    .adc_reset_max_sum (adc_reset_max_sum),
    .s_axis_tvalid     (s_axis_tvalid),
    .s_axis_tdata      (s_axis_tdata),
    .m_axis_tvalid     (m_axis_tvalid),
    .m_axis_tdata      (m_axis_tdata),
    .m_axis_tlast      (m_axis_tlast),
    .m_axis_tready     (m_axis_tready),
    .sts_state         (sts_state),
    .sts_done          (sts_done),
    .sts_overflow      (sts_overflow),
    .sts_count         (sts_count),
`ifdef ADC_CAPTURE_PEAK_EN
    .sts_peak          (sts_peak),
`endif
    .sts_trig_time     (sts_trig_time)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int tests  = 0;
  int failed = 0;

  // Stream monitor: counts beats and tlasts, logs data of each beat
  int          beats    = 0;
  int          lasts    = 0;
  int          last_idx = 0;
  logic [15:0] beat_data [0:255];

  always @(posedge aclk) begin
    if (aresetn && m_axis_tvalid && m_axis_tready) begin
      beat_data[beats % 256] <= m_axis_tdata;
      beats <= beats + 1;
      if (m_axis_tlast) begin
        lasts    <= lasts + 1;
        last_idx <= beats + 1;
      end
      $display("[TB] beat %0d data=%0d last=%0b", beats, m_axis_tdata, m_axis_tlast);
    end
  end

  // Reference timestamp: counts cycles since reset release
  logic [63:0] tb_ts;
  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) tb_ts <= '0;
    else          tb_ts <= tb_ts + 64'd1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge aclk);
  endtask

  task automatic arm(input logic [15:0] level, input logic [31:0] len, input logic [7:0] settle);
    cfg_trig_level = level;
    cfg_post_len   = len;
    cfg_settle     = settle;
    cfg_arm        = 1'b1;
    tick();
    cfg_arm        = 1'b0;
  endtask

  // Waits (bounded) for ARMED and reports how many SETTLE cycles were seen
  task automatic wait_armed(output int n);
    n = 0;
    for (int i = 0; i < 300; i++) begin
      if (sts_state == 3'd3) break;
      if (sts_state == 3'd2) n++;
      tick();
    end
  endtask

  int          n;
  int          b0;
  int          l0;
  logic [63:0] t_arm;

  initial begin
    aresetn        = 1'b0;
    cfg_arm        = 1'b0;
    cfg_abort      = 1'b0;
    cfg_trig_level = '0;
    cfg_post_len   = '0;
    cfg_settle     = '0;
    s_axis_tvalid  = 1'b0;
    s_axis_tdata   = '0;
    m_axis_tready  = 1'b1;
    repeat (3) tick();

    // Reset state
    check("rst_state", sts_state, 3'd0);
    check("rst_reset_trigger", adc_reset_trigger, 1'b1);
    check("rst_reset_max_sum", adc_reset_max_sum, 1'b0);
    check("rst_level", adc_trigger_level, 16'hFFFF);
    check("rst_tvalid", m_axis_tvalid, 1'b0);
    check("rst_done", sts_done, 1'b0);
    check("rst_count", sts_count, 32'd0);
    check("rst_trig_time", sts_trig_time, 64'd0);
    aresetn = 1'b1;
    tick();

    // 1: post_len=8, settle=0; valid held during SETTLE must be ignored
    b0 = beats; l0 = lasts;
    arm(16'h0123, 32'd8, 8'd0);
    check("t1_clear_state", sts_state, 3'd1);
    check("t1_reset_max_sum", adc_reset_max_sum, 1'b1);
    check("t1_level", adc_trigger_level, 16'h0123);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 16'd99;
    wait_armed(n);
    check("t1_settle_len", n, 4);
    check("t1_armed", sts_state, 3'd3);
    check("t1_trig_released", adc_reset_trigger, 1'b0);
    for (int i = 0; i < 20; i++) begin
      s_axis_tdata = 16'(100 + i);
      tick();
    end
    s_axis_tvalid = 1'b0;
    repeat (3) tick();
    check("t1_beats", beats - b0, 8);
    check("t1_lasts", lasts - l0, 1);
    check("t1_first_data", beat_data[b0 % 256], 16'd100);
    check("t1_final_data", beat_data[(b0 + 7) % 256], 16'd107);
    check("t1_tlast_on_8th", last_idx - b0, 8);
    check("t1_count", sts_count, 32'd8);
    check("t1_done", sts_done, 1'b1);
    check("t1_state_done", sts_state, 3'd5);
    check("t1_reset_trigger_done", adc_reset_trigger, 1'b1);
    check("t1_overflow", sts_overflow, 1'b0);

    // 2: post_len=0 behaves as 1
    b0 = beats; l0 = lasts;
    arm(16'h0200, 32'd0, 8'd0);
    check("t2_done_cleared", sts_done, 1'b0);
    check("t2_count_cleared", sts_count, 32'd0);
    wait_armed(n);
    s_axis_tvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      s_axis_tdata = 16'(200 + i);
      tick();
    end
    s_axis_tvalid = 1'b0;
    repeat (3) tick();
    check("t2_beats", beats - b0, 1);
    check("t2_lasts", lasts - l0, 1);
    check("t2_data", beat_data[b0 % 256], 16'd200);
    check("t2_count", sts_count, 32'd1);
    check("t2_state_done", sts_state, 3'd5);

    // 3: post_len=4 with DMA stalled: first beat held, three dropped
    b0 = beats; l0 = lasts;
    m_axis_tready = 1'b0;
    arm(16'h0300, 32'd4, 8'd0);
    wait_armed(n);
    s_axis_tvalid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      s_axis_tdata = 16'(300 + i);
      tick();
    end
    s_axis_tvalid = 1'b0;
    tick();
    check("t3_no_beats", beats - b0, 0);
    check("t3_held_valid", m_axis_tvalid, 1'b1);
    check("t3_held_data", m_axis_tdata, 16'd300);
    check("t3_held_not_last", m_axis_tlast, 1'b0);
    check("t3_overflow", sts_overflow, 1'b1);
    check("t3_count", sts_count, 32'd4);
    check("t3_state_done", sts_state, 3'd5);
    m_axis_tready = 1'b1;
    repeat (2) tick();
    check("t3_drained_beats", beats - b0, 1);
    check("t3_no_tlast", lasts - l0, 0);
    // abort and arm together from DONE: abort wins
    cfg_arm   = 1'b1;
    cfg_abort = 1'b1;
    tick();
    cfg_arm   = 1'b0;
    cfg_abort = 1'b0;
    check("t3_abort_wins_state", sts_state, 3'd0);
    check("t3_abort_wins_done", sts_done, 1'b0);
    check("t3_abort_count_held", sts_count, 32'd4);
    check("t3_abort_overflow_held", sts_overflow, 1'b1);

    // 4: abort on the 3rd CAPTURE cycle, output register flushed
    arm(16'h0400, 32'd100, 8'd0);
    wait_armed(n);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 16'd400;
    repeat (3) tick();
    check("t4_in_capture", sts_state, 3'd4);
    cfg_abort     = 1'b1;
    m_axis_tready = 1'b0;
    tick();
    cfg_abort     = 1'b0;
    s_axis_tvalid = 1'b0;
    check("t4_state_idle", sts_state, 3'd0);
    check("t4_tvalid_flushed", m_axis_tvalid, 1'b0);
    check("t4_count", sts_count, 32'd3);
    check("t4_done", sts_done, 1'b0);
    check("t4_reset_trigger", adc_reset_trigger, 1'b1);
    check("t4_overflow", sts_overflow, 1'b0);
    m_axis_tready = 1'b1;
    tick();

    // 5: trigger timestamp with settle=10; arm pulses during CAPTURE ignored
    b0 = beats; l0 = lasts;
    cfg_trig_level = 16'h0500;
    cfg_post_len   = 32'd3;
    cfg_settle     = 8'd10;
    cfg_arm        = 1'b1;
    t_arm          = tb_ts;
    tick();
    cfg_arm = 1'b0;
    wait_armed(n);
    check("t5_settle_len", n, 10);
    repeat (5) tick();
    check("t5_still_armed", sts_state, 3'd3);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 16'd500;
    tick();
    check("t5_trig_time", sts_trig_time, t_arm + 64'd17);
    cfg_trig_level = 16'h0AAA;
    cfg_post_len   = 32'd50;
    cfg_arm        = 1'b1;
    tick();
    cfg_arm = 1'b0;
    check("t5_arm_ignored_state", sts_state, 3'd4);
    check("t5_arm_ignored_level", adc_trigger_level, 16'h0500);
    tick();
    s_axis_tvalid = 1'b0;
    repeat (2) tick();
    check("t5_count", sts_count, 32'd3);
    check("t5_state_done", sts_state, 3'd5);
    check("t5_beats", beats - b0, 3);
    check("t5_lasts", lasts - l0, 1);

`ifdef ADC_CAPTURE_PEAK_EN
    // 6: peak hold over 5, 900, 12; cleared on re-arm
    arm(16'h0600, 32'd3, 8'd0);
    wait_armed(n);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 16'd5;
    tick();
    s_axis_tdata  = 16'd900;
    tick();
    s_axis_tdata  = 16'd12;
    tick();
    s_axis_tvalid = 1'b0;
    tick();
    check("t6_peak", sts_peak, 16'd900);
    check("t6_state_done", sts_state, 3'd5);
    arm(16'h0600, 32'd1, 8'd0);
    check("t6_peak_cleared", sts_peak, 16'd0);
    cfg_abort = 1'b1;
    tick();
    cfg_abort = 1'b0;
    tick();
`endif

    // 7: asynchronous reset mid-capture
    l0 = lasts;
    arm(16'h0700, 32'd100, 8'd0);
    wait_armed(n);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 16'd700;
    repeat (3) tick();
    check("t7_in_capture", sts_state, 3'd4);
    aresetn = 1'b0;
    #1;
    check("t7_rst_state", sts_state, 3'd0);
    check("t7_rst_tvalid", m_axis_tvalid, 1'b0);
    check("t7_rst_tlast", m_axis_tlast, 1'b0);
    check("t7_rst_count", sts_count, 32'd0);
    check("t7_rst_level", adc_trigger_level, 16'hFFFF);
    check("t7_rst_trig_time", sts_trig_time, 64'd0);
    check("t7_rst_reset_trigger", adc_reset_trigger, 1'b1);
    s_axis_tvalid = 1'b0;
    tick();
    aresetn = 1'b1;
    repeat (2) tick();
    check("t7_no_tlast", lasts - l0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
